// File: rtl/zx_clock_sequencer_if.sv
// Bundle of the sequencer's lock/contention inputs and its reset, enable and phase outputs.
interface zx_clock_sequencer_if;
   logic       locked;
   logic       contend;
   logic       sys_rst_n;
   logic       ne14M;
   logic       pe7M;
   logic       ne7M;
   logic       pe3M5;
   logic       ne3M5;
   logic       ce_psg;
   logic [4:0] phase;

   modport master (
      output locked, contend,
      input  sys_rst_n, ne14M, pe7M, ne7M, pe3M5, ne3M5, ce_psg, phase
   );

   modport slave (
      input  locked, contend,
      output sys_rst_n, ne14M, pe7M, ne7M, pe3M5, ne3M5, ce_psg, phase
   );
endinterface

// File: rtl/zx_clock_sequencer.sv
// Holds the core in reset until the PLL lock is stable, then derives video/CPU/PSG
// clock enables from a free-running 5-bit divider of the 56.75 MHz clock.
module zx_clock_sequencer #(
   parameter int LOCK_CYCLES = 4096
) (
   input logic                 clock,
   input logic                 reset,
   zx_clock_sequencer_if.slave bus
);
   localparam int CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             lock_meta_q, lock_meta_d;
   logic             lock_sync_q, lock_sync_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [4:0]       div_q, div_d;
   logic             stall_q, stall_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             ne14m_q, ne14m_d;
   logic             pe7m_q, pe7m_d;
   logic             ne7m_q, ne7m_d;
   logic             pe3m5_q, pe3m5_d;
   logic             ne3m5_q, ne3m5_d;
   logic             ce_psg_q, ce_psg_d;
   logic             run_d;

   // Next-state, divider and enable decode; outputs are decoded from div_d so the
   // registered pulse lines up with the cycle in which div_q holds the slot value.
   always_comb begin
      lock_meta_d = bus.locked;
      lock_sync_d = lock_meta_q;
      state_d     = state_q;
      lock_cnt_d  = '0;

      case (state_q)
         WAIT_LOCK: begin
            if (lock_sync_q) state_d = STABLE;
            else             state_d = WAIT_LOCK;
         end
         STABLE: begin
            if (!lock_sync_q) begin
               state_d = WAIT_LOCK;
            end else if (lock_cnt_q == CNT_MAX) begin
               state_d = RUN;
            end else begin
               state_d    = STABLE;
               lock_cnt_d = lock_cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lock_sync_q) state_d = WAIT_LOCK;
            else              state_d = RUN;
         end
         default: state_d = WAIT_LOCK;
      endcase

      run_d = (state_d == RUN);

      // The first RUN cycle shows div = 0; leaving RUN clears div on the same edge.
      if (run_d && (state_q == RUN)) div_d = div_q + 5'd1;
      else                           div_d = 5'd0;

      if (!run_d)                     stall_d = 1'b0;
      else if (div_d[3:0] == 4'd7)    stall_d = bus.contend;
      else                            stall_d = stall_q;

      sys_rst_n_d = run_d;
      ne14m_d     = run_d && (div_d[1:0] == 2'd3);
      pe7m_d      = run_d && (div_d[2:0] == 3'd3);
      ne7m_d      = run_d && (div_d[2:0] == 3'd7);
      pe3m5_d     = run_d && (div_d[3:0] == 4'd7) && !bus.contend;
      ne3m5_d     = run_d && (div_d[3:0] == 4'd15) && !stall_q;
      ce_psg_d    = run_d && (div_d == 5'd31);
   end

   // State, synchronizer, divider and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= WAIT_LOCK;
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
         lock_cnt_q  <= '0;
         div_q       <= 5'd0;
         stall_q     <= 1'b0;
         sys_rst_n_q <= 1'b0;
         ne14m_q     <= 1'b0;
         pe7m_q      <= 1'b0;
         ne7m_q      <= 1'b0;
         pe3m5_q     <= 1'b0;
         ne3m5_q     <= 1'b0;
         ce_psg_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         lock_meta_q <= lock_meta_d;
         lock_sync_q <= lock_sync_d;
         lock_cnt_q  <= lock_cnt_d;
         div_q       <= div_d;
         stall_q     <= stall_d;
         sys_rst_n_q <= sys_rst_n_d;
         ne14m_q     <= ne14m_d;
         pe7m_q      <= pe7m_d;
         ne7m_q      <= ne7m_d;
         pe3m5_q     <= pe3m5_d;
         ne3m5_q     <= ne3m5_d;
         ce_psg_q    <= ce_psg_d;
      end
   end

   assign bus.sys_rst_n = sys_rst_n_q;
   assign bus.ne14M     = ne14m_q;
   assign bus.pe7M      = pe7m_q;
   assign bus.ne7M      = ne7m_q;
   assign bus.pe3M5     = pe3m5_q;
   assign bus.ne3M5     = ne3m5_q;
   assign bus.ce_psg    = ce_psg_q;
   assign bus.phase     = div_q;
endmodule

// File: tb/tb_zx_clock_sequencer.sv
// Scoreboard bench: per-cycle expected output vectors are queued as stimulus is
// applied and compared at each falling edge against the sequencer outputs.
module tb_zx_clock_sequencer;
   localparam int LOCKN  = 16;
   localparam int R0     = 10 + 2 + LOCKN + 1;  // locked rises in cycle 10
   localparam int SUP_PE = R0 + 71;             // a phase-7 slot in the third pass
   localparam int SUP_NE = R0 + 79;             // its matching phase-15 slot
   localparam int NOSUP  = R0 + 87;             // next phase-7 slot: contend after it

   typedef struct {
      int          cyc;
      logic [11:0] v;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb[$];
   int   n_ne14, n_pe7, n_ne7, n_pe35, n_ne35, n_psg;

   zx_clock_sequencer_if bus ();

   zx_clock_sequencer #(.LOCK_CYCLES(LOCKN)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] obs_vec();
      return {bus.sys_rst_n, bus.ne14M, bus.pe7M, bus.ne7M,
              bus.pe3M5, bus.ne3M5, bus.ce_psg, bus.phase};
   endfunction

   function automatic logic [11:0] run_vec(input int ph, input bit sup_pe, input bit sup_ne);
      logic [4:0] p;
      p = ph[4:0];
      return {1'b1, p[1:0] == 2'd3, p[2:0] == 3'd3, p[2:0] == 3'd7,
              (p[3:0] == 4'd7) && !sup_pe, (p[3:0] == 4'd15) && !sup_ne,
              p == 5'd31, p};
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic push_zero(input int from, input int to);
      for (int c = from; c <= to; c++) sb.push_back('{cyc: c, v: 12'd0});
   endtask

   task automatic push_run(input int from, input int to, input int start);
      for (int c = from; c <= to; c++)
         sb.push_back('{cyc: c, v: run_vec(c - start, c == SUP_PE, c == SUP_NE)});
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Compare queued expectations for this cycle and tally pulses over the first 64 RUN cycles.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         exp_t e;
         e = sb.pop_front();
         check_val($sformatf("cyc%0d", e.cyc), {20'd0, obs_vec()}, {20'd0, e.v});
      end
      if (cyc >= R0 && cyc < R0 + 64) begin
         n_ne14 += int'(bus.ne14M);
         n_pe7  += int'(bus.pe7M);
         n_ne7  += int'(bus.ne7M);
         n_pe35 += int'(bus.pe3M5);
         n_ne35 += int'(bus.ne3M5);
         n_psg  += int'(bus.ce_psg);
      end
   end

   initial begin
      checks = 0; errors = 0;
      n_ne14 = 0; n_pe7 = 0; n_ne7 = 0; n_pe35 = 0; n_ne35 = 0; n_psg = 0;
      rst_n = 1'b0;
      bus.locked = 1'b0;
      bus.contend = 1'b0;
      push_zero(1, R0 - 1);
      push_run(R0, R0 + 127, R0);

      wait_cyc(5);
      rst_n = 1'b1;
      wait_cyc(10);
      bus.locked = 1'b1;

      // contend present at the edge entering phase 7 suppresses that CPU period
      wait_cyc(SUP_PE - 1);
      bus.contend = 1'b1;
      wait_cyc(SUP_PE);
      bus.contend = 1'b0;
      // contend raised after the slot edge must be ignored
      wait_cyc(NOSUP);
      bus.contend = 1'b1;
      wait_cyc(NOSUP + 1);
      bus.contend = 1'b0;

      // lock lost in RUN
      wait_cyc(R0 + 128);
      push_run(R0 + 128, R0 + 130, R0);
      push_zero(R0 + 131, 203);
      bus.locked = 1'b0;

      // lock lost part-way through STABLE, then a fresh full lock window
      wait_cyc(170);
      bus.locked = 1'b1;
      wait_cyc(180);
      bus.locked = 1'b0;
      wait_cyc(185);
      push_run(204, 214, 204);
      bus.locked = 1'b1;

      // asynchronous reset between edges while running
      wait_cyc(215);
      #2;
      push_zero(215, 236);
      rst_n = 1'b0;
      #1;
      check_val("async_rst", {20'd0, obs_vec()}, 32'd0);
      wait_cyc(218);
      push_run(237, 277, 237);
      rst_n = 1'b1;

      wait_cyc(280);
      check_val("cnt_ne14M", n_ne14, 32'd16);
      check_val("cnt_pe7M",  n_pe7,  32'd8);
      check_val("cnt_ne7M",  n_ne7,  32'd8);
      check_val("cnt_pe3M5", n_pe35, 32'd4);
      check_val("cnt_ne3M5", n_ne35, 32'd4);
      check_val("cnt_psg",   n_psg,  32'd2);
      check_val("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
